// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises instruction-fetch and data accesses onto one
// synchronous single-port memory with a configurable read latency.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, ACK} state_t;

    state_t     r_state;
    logic       r_owner;
    logic       r_last;
    logic       r_we;
    logic       r_mask_i;
    logic       r_mask_d;
    logic [1:0] r_cnt;
    logic       w_i;
    logic       w_d;
    logic       w_gnt_d;

    assign w_i = i_req & ~r_mask_i;
    assign w_d = d_req & ~r_mask_d;
    // on a tie the data port wins only when the fetch port was granted last
    assign w_gnt_d = w_d & (~w_i | ~r_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_owner   <= 1'b0;
            r_last    <= 1'b1;
            r_we      <= 1'b0;
            r_mask_i  <= 1'b0;
            r_mask_d  <= 1'b0;
            r_cnt     <= 2'd0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_mask_i <= 1'b0;
                    r_mask_d <= 1'b0;
                    if (w_i || w_d) begin
                        r_state  <= ACCESS;
                        r_owner  <= w_gnt_d;
                        r_last   <= w_gnt_d;
                        r_we     <= w_gnt_d & d_we;
                        mem_en   <= 1'b1;
                        mem_we   <= w_gnt_d & d_we;
                        mem_addr <= w_gnt_d ? d_addr : i_addr;
                        if (w_gnt_d)
                            mem_wdata <= d_wdata;
                    end
                end
                ACCESS: begin
                    mem_en  <= 1'b0;
                    mem_we  <= 1'b0;
                    r_cnt   <= 2'(MEM_LAT - 1);
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (r_cnt == 2'd0) begin
                        if (!r_owner)
                            i_rdata <= mem_rdata;
                        else if (!r_we)
                            d_rdata <= mem_rdata;
                        i_ack   <= ~r_owner;
                        d_ack   <= r_owner;
                        r_state <= ACK;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                ACK: begin
                    i_ack    <= 1'b0;
                    d_ack    <= 1'b0;
                    r_mask_i <= ~r_owner;
                    r_mask_d <= r_owner;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter at MEM_LAT = 1..4, one
// instance per latency, each with its own pipelined memory model.
`timescale 1ns/1ps
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        preload = 1'b1;
    logic        i_req[4], i_ack[4], d_req[4], d_we[4], d_ack[4], mem_en[4], mem_we[4];
    logic [31:0] i_addr[4], i_rdata[4], d_addr[4], d_wdata[4], d_rdata[4];
    logic [31:0] mem_addr[4], mem_wdata[4];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : G
        logic [31:0] mem [64];
        logic [31:0] p [4];
        mem_arbiter #(.MEM_LAT(g + 1)) u_dut (
            .clk(clk), .reset(reset),
            .i_req(i_req[g]), .i_addr(i_addr[g]), .i_ack(i_ack[g]), .i_rdata(i_rdata[g]),
            .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
            .d_ack(d_ack[g]), .d_rdata(d_rdata[g]),
            .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
            .mem_wdata(mem_wdata[g]), .mem_rdata(p[g])
        );
        // read data appears in stage g, i.e. g+1 cycles after the enable cycle
        always @(posedge clk) begin
            if (preload) begin
                for (int j = 0; j < 64; j++) mem[j] <= 32'hC0DE_0000 + j;
                mem[4] <= 32'h0050_0093;
            end else if (mem_en[g] && mem_we[g]) begin
                mem[mem_addr[g][7:2]] <= mem_wdata[g];
            end
            if (mem_en[g] && !mem_we[g]) p[0] <= mem[mem_addr[g][7:2]];
            for (int j = 1; j < 4; j++) p[j] <= p[j-1];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ack(input int k, input bit dp, input bit drop, output int n, output int we_n);
        n = -1;
        we_n = 0;
        for (int c = 1; c <= 20 && n < 0; c++) begin
            step();
            if (mem_we[k]) we_n++;
            if (dp ? d_ack[k] : i_ack[k]) n = c;
        end
        if (drop) begin
            if (dp) d_req[k] = 1'b0;
            else i_req[k] = 1'b0;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        int n, w, na;
        int ac[4];
        bit ap[4];
        for (int k = 0; k < 4; k++) begin
            i_req[k] = 1'b0; d_req[k] = 1'b0; d_we[k] = 1'b0;
            i_addr[k] = '0; d_addr[k] = '0; d_wdata[k] = '0;
        end
        repeat (2) step();
        preload = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("rst_iack", i_ack[k], 1'b0);
            chk("rst_dack", d_ack[k], 1'b0);
            chk("rst_en", mem_en[k], 1'b0);
            chk("rst_we", mem_we[k], 1'b0);
            chk("rst_addr", mem_addr[k], 32'h0);
            chk("rst_wdata", mem_wdata[k], 32'h0);
            chk("rst_irdata", i_rdata[k], 32'h0);
            chk("rst_drdata", d_rdata[k], 32'h0);
        end
        reset = 1'b0;
        step();

        // single fetch, latency 1
        i_addr[0] = 32'h10; i_req[0] = 1'b1;
        step();
        chk("f_en", mem_en[0], 1'b1);
        chk("f_addr", mem_addr[0], 32'h10);
        chk("f_we", mem_we[0], 1'b0);
        step();
        chk("f_early", i_ack[0], 1'b0);
        step();
        chk("f_ack", i_ack[0], 1'b1);
        chk("f_data", i_rdata[0], 32'h0050_0093);
        chk("f_dack", d_ack[0], 1'b0);
        i_req[0] = 1'b0;
        step();
        chk("f_pulse", i_ack[0], 1'b0);

        // store then load, latency 2
        d_we[1] = 1'b1; d_addr[1] = 32'h40; d_wdata[1] = 32'hDEAD_BEEF; d_req[1] = 1'b1;
        wait_ack(1, 1'b1, 1'b1, n, w);
        chk("st_ack", n, 4);
        chk("st_we", w, 1);
        chk("st_rdata", d_rdata[1], 32'h0);
        step(); step();
        d_we[1] = 1'b0; d_req[1] = 1'b1;
        wait_ack(1, 1'b1, 1'b1, n, w);
        chk("ld_ack", n, 4);
        chk("ld_we", w, 0);
        chk("ld_data", d_rdata[1], 32'hDEAD_BEEF);

        // simultaneous requests out of reset alternate I, D, I, D
        reset = 1'b1; step(); reset = 1'b0;
        i_addr[0] = 32'h10; d_addr[0] = 32'h20; d_we[0] = 1'b0;
        i_req[0] = 1'b1; d_req[0] = 1'b1; na = 0;
        for (int c = 1; c <= 17; c++) begin
            step();
            if (na < 4 && (i_ack[0] || d_ack[0])) begin
                ac[na] = c; ap[na] = d_ack[0]; na++;
            end
        end
        i_req[0] = 1'b0; d_req[0] = 1'b0;
        chk("alt_n", na, 4);
        for (int j = 0; j < na; j++) begin
            chk("alt_cyc", ac[j], 3 + 4 * j);
            chk("alt_own", ap[j], j % 2);
        end
        chk("alt_idata", i_rdata[0], 32'h0050_0093);
        chk("alt_ddata", d_rdata[0], 32'hC0DE_0008);
        repeat (6) step();

        // held fetch request is masked for one IDLE cycle
        i_addr[0] = 32'h14; i_req[0] = 1'b1;
        wait_ack(0, 1'b0, 1'b0, n, w);
        chk("h_ack", n, 3);
        chk("h_data", i_rdata[0], 32'hC0DE_0005);
        step(); step();
        chk("h_mask", mem_en[0], 1'b0);
        step();
        chk("h_regrant", mem_en[0], 1'b1);
        i_req[0] = 1'b0;
        step(); step();
        chk("h_ack2", i_ack[0], 1'b1);

        // reset during WAIT of a load, latency 3
        d_we[2] = 1'b0; d_addr[2] = 32'h24; d_req[2] = 1'b1;
        wait_ack(2, 1'b1, 1'b1, n, w);
        chk("r_ack1", n, 5);
        chk("r_d1", d_rdata[2], 32'hC0DE_0009);
        step(); step();
        d_addr[2] = 32'h28; d_req[2] = 1'b1;
        step(); step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0; d_req[2] = 1'b0;
        chk("r_dack", d_ack[2], 1'b0);
        chk("r_en", mem_en[2], 1'b0);
        chk("r_addr", mem_addr[2], 32'h0);
        chk("r_rd", d_rdata[2], 32'h0);
        n = 0;
        repeat (8) begin
            step();
            if (d_ack[2]) n++;
        end
        chk("r_noack", n, 0);
        d_addr[2] = 32'h2C; d_req[2] = 1'b1;
        wait_ack(2, 1'b1, 1'b1, n, w);
        chk("r_ack2", n, 5);
        chk("r_d2", d_rdata[2], 32'hC0DE_000B);

        // latency 4: address held through ACCESS and all WAIT cycles
        i_addr[3] = 32'h30; i_req[3] = 1'b1;
        n = -1;
        for (int c = 1; c <= 12 && n < 0; c++) begin
            step();
            if (c <= 5) chk("l4_addr", mem_addr[3], 32'h30);
            chk("l4_en", mem_en[3], c == 1);
            if (i_ack[3]) n = c;
        end
        i_req[3] = 1'b0;
        chk("l4_ack", n, 6);
        chk("l4_data", i_rdata[3], 32'hC0DE_000C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
